uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter DATA_W, default 8, byte width per frame.
REQ-003 Parameter TIMEOUT, default 2000, max cycles from tx_start to tx_done before abort.
REQ-004 CLK  input  1  single clock; all logic on rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 req  input  N_REQ  per-requester send request, level, held until granted.
REQ-007 req_data  input  N_REQ*DATA_W  per-requester byte; slice i = bits [i*DATA_W +: DATA_W].
REQ-008 grant  output  N_REQ  one-hot, one-cycle acknowledge to the winning requester.
REQ-009 tx_start  output  1  one-cycle launch pulse to the UART transmitter.
REQ-010 tx_data  output  DATA_W  registered byte to transmit, stable from tx_start until frame end.
REQ-011 tx_done  input  1  one-cycle pulse from the transmitter at end of the stop bit.
REQ-012 busy  output  1  high while a frame is owned (LAUNCH or WAIT_DONE).
REQ-013 owner  output  clog2(N_REQ)  index of the current or last granted requester.
REQ-014 err  output  1  one-cycle pulse on timeout abort.

Function
REQ-015 FSM states: IDLE, LAUNCH, WAIT_DONE.
REQ-016 IDLE: if any req bit is high, select the winner, latch its req_data into tx_data and its index into owner, then go to LAUNCH; otherwise stay.
REQ-017 Arbitration is round-robin: search starts at (last_owner+1) mod N_REQ and wraps; the first set req bit wins.
REQ-018 LAUNCH lasts exactly one cycle: tx_start=1 and grant[owner]=1, then go to WAIT_DONE.
REQ-019 Latency: req sampled high in IDLE at edge t causes tx_start/grant high in cycle t+1.
REQ-020 Requester holds req and req_data stable until grant, then drops req or presents its next byte.
REQ-021 WAIT_DONE: on tx_done go to IDLE, last_owner <= owner; a new grant is possible one cycle later.
REQ-022 tx_done is ignored in IDLE and in LAUNCH.
REQ-023 Timeout counter: 16 bits, cleared in LAUNCH, increments each WAIT_DONE cycle; on reaching TIMEOUT-1 without tx_done: err=1 for one cycle, go to IDLE, advance last_owner.
REQ-024 tx_done and the timeout in the same cycle: tx_done wins and err stays 0.
REQ-025 req changes while busy are ignored; there is no preemption.
REQ-026 A single requester asserting continuously is granted once per frame; with all requesters high, grants rotate 0,1,2,3,0...
REQ-027 If N_REQ is not a power of two, the index wrap uses explicit compare-to-(N_REQ-1), never bit truncation.

Reset
REQ-028 RST, regardless of state, forces: state=IDLE, tx_start=0, grant=0, err=0, busy=0, tx_data=0, owner=0, timeout counter=0, last_owner=N_REQ-1 (requester 0 has first priority).
REQ-029 Reset mid-frame issues no further tx_start; the transmitter is reset by the same RST.

Structure
REQ-030 FSM state encodings and the default TIMEOUT value go in the shared UART constants package, alongside the receiver state codes.
REQ-031 Round-robin winner selection is one combinational sub-module, rr_pick (inputs req and last_owner; outputs valid and index).
REQ-032 Single sequential always block for state and registers; next-state and output decode are combinational with defaults assigned.

Verification
REQ-033 Reset, then req=4'b0001 with data 8'hA5: tx_start and grant=0001 one cycle later, tx_data=8'hA5; after tx_done, busy=0.
REQ-034 req=4'b1111 held with data 8'h10/8'h11/8'h12/8'h13 and tx_done returned 10 cycles after each start: tx_data order is 10,11,12,13,10.
REQ-035 After granting requester 2, req=4'b0101: the next grant goes to requester 0 (wrap), not requester 2.
REQ-036 No tx_done after a launch: err pulses at cycle TIMEOUT after tx_start, state returns to IDLE, and the next grant goes to the next requester.
REQ-037 RST asserted in WAIT_DONE: all outputs zero the next cycle; with req=4'b1000 after release, requester 3 is granted with tx_start high.
REQ-038 tx_done pulsed in IDLE with req=0: no state change, no err, no grant.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART constants: transmit-arbiter and receiver state codes, default timeout.
package uart_tx_arbiter_pkg;

  localparam int TIMEOUT_DEFAULT = 2000;
  localparam int TMO_CNT_W       = 16;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_LAUNCH    = 2'd1,
    ARB_WAIT_DONE = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin winner select: first set request after last_owner, wrapping
// by compare so non-power-of-two requester counts index correctly.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_owner,
  output logic             valid,
  output logic [IW-1:0]    index
);

  localparam int IW1 = IW + 1;

  logic [IW1-1:0] cand;
  logic           found;

  always_comb begin
    cand  = '0;
    found = 1'b0;
    index = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, last_owner} + IW1'(k);
      if (cand >= IW1'(N_REQ)) cand = cand - IW1'(N_REQ);
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        index = cand[IW-1:0];
      end
    end
    valid = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ requesters: round-robin grant,
// one-cycle launch, then wait for tx_done or abort on timeout.
//
// state     | meaning
// IDLE      | no frame owned; pick a winner when any req is high
// LAUNCH    | one cycle: tx_start and grant to the owner
// WAIT_DONE | frame in flight; leave on tx_done or timeout
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int IW      = $clog2(N_REQ)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          grant,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic                      busy,
  output logic [IW-1:0]             owner,
  output logic                      err
);

  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);

  arb_state_e             state_q, state_d;
  logic [DATA_W-1:0]      tx_data_q, tx_data_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic [IW-1:0]          last_q, last_d;
  logic [TMO_CNT_W-1:0]   cnt_q, cnt_d;

  logic                   pick_valid;
  logic [IW-1:0]          pick_idx;

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_rr_pick (
    .req        (req),
    .last_owner (last_q),
    .valid      (pick_valid),
    .index      (pick_idx)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ARB_IDLE;
      tx_data_q <= '0;
      owner_q   <= '0;
      last_q    <= IW'(N_REQ - 1);
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    grant     = '0;
    tx_start  = 1'b0;
    busy      = 1'b0;
    err       = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          owner_d   = pick_idx;
          tx_data_d = req_data[pick_idx*DATA_W +: DATA_W];
          state_d   = ARB_LAUNCH;
        end
      end
      ARB_LAUNCH: begin
        tx_start       = 1'b1;
        busy           = 1'b1;
        grant[owner_q] = 1'b1;
        cnt_d          = '0;
        state_d        = ARB_WAIT_DONE;
      end
      ARB_WAIT_DONE: begin
        busy = 1'b1;
        // tx_done takes precedence over a coincident timeout
        if (tx_done) begin
          last_d  = owner_q;
          state_d = ARB_IDLE;
        end else if (cnt_q == TMO_LAST) begin
          err     = 1'b1;
          last_d  = owner_q;
          state_d = ARB_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign tx_data = tx_data_q;
  assign owner   = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters, short timeout).
module tb_uart_tx_arbiter;

  localparam int N_REQ   = 4;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 20;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic [1:0]  owner;
  logic        err;

  int total;
  int bad;

  uart_tx_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK      (clk),
    .RST      (rst),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .busy     (busy),
    .owner    (owner),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_frame();
    req = 4'b0000;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_data = '0; tx_done = 1'b0;
    tick(); tick();
    total++;
    if ({tx_start, grant, busy, err} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got start=%b grant=%b busy=%b err=%b, want all 0", tx_start, grant, busy, err);
    end
    total++;
    if (tx_data !== 8'h00 || owner !== 2'd0) begin
      bad++;
      $display("FAIL reset_regs: got tx_data=%h owner=%0d, want 00 / 0", tx_data, owner);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    req = 4'b0001; req_data = 32'h000000A5;
    tick();
    total++;
    if (tx_start !== 1'b1 || grant !== 4'b0001 || tx_data !== 8'hA5 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_launch: got start=%b grant=%b data=%h busy=%b, want 1/0001/a5/1", tx_start, grant, tx_data, busy);
    end
    req = 4'b0000;
    tick();
    total++;
    if (tx_start !== 1'b0 || grant !== 4'b0000 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_wait: got start=%b grant=%b busy=%b, want 0/0000/1", tx_start, grant, busy);
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    total++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL single_done: got busy=%b err=%b, want 0/0", busy, err);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_data [5];
    logic [3:0] exp_grant [5];
    exp_data  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    exp_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111; req_data = 32'h13121110;
    for (int f = 0; f < 5; f++) begin
      tick();
      total++;
      if (tx_start !== 1'b1 || grant !== exp_grant[f] || tx_data !== exp_data[f]) begin
        bad++;
        $display("FAIL rr_frame%0d: got start=%b grant=%b data=%h, want 1/%b/%h", f, tx_start, grant, tx_data, exp_grant[f], exp_data[f]);
      end
      repeat (10) tick();
      total++;
      if (tx_data !== exp_data[f] || busy !== 1'b1 || tx_start !== 1'b0) begin
        bad++;
        $display("FAIL rr_hold%0d: got data=%h busy=%b start=%b, want %h/1/0", f, tx_data, busy, tx_start, exp_data[f]);
      end
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      total++;
      if (busy !== 1'b0 || tx_start !== 1'b0 || err !== 1'b0) begin
        bad++;
        $display("FAIL rr_idle%0d: got busy=%b start=%b err=%b, want 0/0/0", f, busy, tx_start, err);
      end
    end
    req = 4'b0000;
    tick();
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic test_wrap();
    req = 4'b0100; req_data = 32'h00220020;
    tick();
    total++;
    if (grant !== 4'b0100 || tx_data !== 8'h22) begin
      bad++;
      $display("FAIL wrap_first: got grant=%b data=%h, want 0100/22", grant, tx_data);
    end
    finish_frame();
    req = 4'b0101;
    tick();
    total++;
    if (grant !== 4'b0001 || owner !== 2'd0 || tx_data !== 8'h20) begin
      bad++;
      $display("FAIL wrap_next: got grant=%b owner=%0d data=%h, want 0001/0/20", grant, owner, tx_data);
    end
    finish_frame();
  endtask

  task automatic test_timeout();
    req = 4'b0010; req_data = 32'h00003130;
    tick();
    total++;
    if (tx_start !== 1'b1 || grant !== 4'b0010) begin
      bad++;
      $display("FAIL tmo_launch: got start=%b grant=%b, want 1/0010", tx_start, grant);
    end
    req = 4'b0011;
    for (int k = 1; k < TIMEOUT; k++) begin
      tick();
      total++;
      if (err !== 1'b0 || busy !== 1'b1 || grant !== 4'b0000) begin
        bad++;
        $display("FAIL tmo_wait%0d: got err=%b busy=%b grant=%b, want 0/1/0000", k, err, busy, grant);
      end
    end
    tick();
    total++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL tmo_err: got err=%b busy=%b, want 1/1", err, busy);
    end
    tick();
    total++;
    if (err !== 1'b0 || busy !== 1'b0 || tx_start !== 1'b0) begin
      bad++;
      $display("FAIL tmo_idle: got err=%b busy=%b start=%b, want 0/0/0", err, busy, tx_start);
    end
    tick();
    total++;
    if (tx_start !== 1'b1 || grant !== 4'b0001 || tx_data !== 8'h30) begin
      bad++;
      $display("FAIL tmo_next: got start=%b grant=%b data=%h, want 1/0001/30", tx_start, grant, tx_data);
    end
    finish_frame();
  endtask

  task automatic test_reset_mid();
    req = 4'b0001; req_data = 32'h83000040;
    tick();
    req = 4'b0000;
    tick(); tick();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_busy: got busy=%b, want 1", busy);
    end
    rst = 1'b1;
    tick();
    total++;
    if ({tx_start, grant, busy, err} !== 7'b0 || tx_data !== 8'h00 || owner !== 2'd0) begin
      bad++;
      $display("FAIL rstmid_clear: got start=%b grant=%b busy=%b err=%b data=%h owner=%0d, want zeros", tx_start, grant, busy, err, tx_data, owner);
    end
    rst = 1'b0;
    req = 4'b1000;
    tick();
    total++;
    if (tx_start !== 1'b1 || grant !== 4'b1000 || owner !== 2'd3 || tx_data !== 8'h83) begin
      bad++;
      $display("FAIL rstmid_grant: got start=%b grant=%b owner=%0d data=%h, want 1/1000/3/83", tx_start, grant, owner, tx_data);
    end
    finish_frame();
  endtask

  task automatic test_done_idle();
    req = 4'b0000;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (busy !== 1'b0 || err !== 1'b0 || grant !== 4'b0000 || tx_start !== 1'b0 || owner !== 2'd3) begin
        bad++;
        $display("FAIL done_idle%0d: got busy=%b err=%b grant=%b start=%b owner=%0d, want 0/0/0000/0/3", k, busy, err, grant, tx_start, owner);
      end
      tick();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_reset_mid();
    test_done_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
